// File: rtl/core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : core_scheduler
// Description : Per-core block sequencer; fetch/decode/request/wait/execute/
//               update loop with PC, fetch handshake and thread enable mask.
// Revision    : 1.0 - initial release
// ============================================================================
module core_scheduler #(
   parameter int THREADS_PER_BLOCK     = 4,
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [7:0]                       block_id,
   input  logic [7:0]                       thread_count,
   output logic                             done,
   output logic                             instr_mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] instr_mem_read_address,
   input  logic                             instr_mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_mem_read_data,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   output logic [7:0]                       latched_block_id,
   output logic [THREADS_PER_BLOCK-1:0]     thread_enable,
   input  logic [THREADS_PER_BLOCK-1:0]     lsu_busy,
   output logic [2:0]                       core_state
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_FETCH   = 3'd1;
   localparam logic [2:0] c_DECODE  = 3'd2;
   localparam logic [2:0] c_REQUEST = 3'd3;
   localparam logic [2:0] c_WAIT    = 3'd4;
   localparam logic [2:0] c_EXECUTE = 3'd5;
   localparam logic [2:0] c_UPDATE  = 3'd6;
   localparam logic [2:0] c_DONE    = 3'd7;

   localparam logic [3:0] c_OP_JMP = 4'h9;
   localparam logic [3:0] c_OP_RET = 4'hF;

   logic [2:0]                       r_state;
   logic [2:0]                       w_next_state;
   logic                             r_done;
   logic                             r_valid;
   logic                             w_done_next;
   logic                             w_valid_next;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] r_pc;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] w_pc_next;
   logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;
   logic [7:0]                       r_block_id;
   logic [THREADS_PER_BLOCK-1:0]     r_thread_enable;
   logic [THREADS_PER_BLOCK-1:0]     w_enable_mask;
   logic [3:0]                       w_opcode;
   logic                             w_start_block;
   logic                             w_fetch_accept;
   logic                             w_lsu_wait;

   assign w_opcode       = r_instruction[PROGRAM_MEM_DATA_BITS-1 -: 4];
   assign w_start_block  = (r_state == c_IDLE) && start && !r_done;
   assign w_fetch_accept = (r_state == c_FETCH) && instr_mem_read_ready;
   // Busy flags of threads outside the block must never stall the core.
   assign w_lsu_wait     = |(lsu_busy & r_thread_enable);

   // Thread i is enabled iff i < min(thread_count, THREADS_PER_BLOCK).
   generate
      for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_enable
         assign w_enable_mask[i] = ({24'd0, thread_count} > 32'(i));
      end
   endgenerate

   // State register, including the registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_done_next;
         r_valid <= w_valid_next;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:    if (w_start_block)
                       w_next_state = (thread_count == 8'd0) ? c_DONE : c_FETCH;
         c_FETCH:   if (w_fetch_accept) w_next_state = c_DECODE;
         c_DECODE:  w_next_state = c_REQUEST;
         c_REQUEST: w_next_state = c_WAIT;
         c_WAIT:    if (!w_lsu_wait) w_next_state = c_EXECUTE;
         c_EXECUTE: w_next_state = c_UPDATE;
         c_UPDATE:  w_next_state = (w_opcode == c_OP_RET) ? c_DONE : c_FETCH;
         c_DONE:    if (!start) w_next_state = c_IDLE;
         default:   w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      w_valid_next = (w_next_state == c_FETCH);
      w_done_next  = (w_next_state == c_DONE);
      w_pc_next    = r_pc;
      if (w_start_block) begin
         w_pc_next = '0;
      end else if (r_state == c_UPDATE) begin
         if (w_opcode == c_OP_JMP)
            w_pc_next = r_instruction[PROGRAM_MEM_ADDR_BITS-1:0];
         else if (w_opcode != c_OP_RET)
            w_pc_next = r_pc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc            <= '0;
         r_instruction   <= '0;
         r_block_id      <= '0;
         r_thread_enable <= '0;
      end else begin
         r_pc <= w_pc_next;
         if (w_fetch_accept)
            r_instruction <= instr_mem_read_data;
         if (w_start_block) begin
            r_block_id      <= block_id;
            r_thread_enable <= w_enable_mask;
         end
      end
   end

   assign done                   = r_done;
   assign instr_mem_read_valid   = r_valid;
   assign instr_mem_read_address = r_pc;
   assign instruction            = r_instruction;
   assign current_pc             = r_pc;
   assign latched_block_id       = r_block_id;
   assign thread_enable          = r_thread_enable;
   assign core_state             = r_state;

endmodule
`default_nettype wire

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Core-side end of the block dispatch handshake: accepts start/block_id/thread_count from the kernel dispatcher, runs one block to completion, and returns done.
- Sequences the core's per-instruction pipeline: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE.
- Owns the PC, the instruction-memory fetch handshake and the thread enable mask; waits on per-thread LSU busy flags.
- One instance per core.

Parameters:
- THREADS_PER_BLOCK, 4, threads per core; width of the enable and busy vectors.
- PROGRAM_MEM_ADDR_BITS, 8, PC and instruction address width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width; opcode = instruction[PROGRAM_MEM_DATA_BITS-1 -: 4].

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high; driven by the dispatcher's per-core reset.
- start  in  1  block dispatch request; held high by the dispatcher until it sees done.
- block_id  in  8  block index; sampled at block start.
- thread_count  in  8  active threads in the block; sampled at block start.
- done  out  1  block complete; held until start drops.
- instr_mem_read_valid  out  1  fetch request.
- instr_mem_read_address  out  PROGRAM_MEM_ADDR_BITS  fetch address; always equals current_pc.
- instr_mem_read_ready  in  1  fetch data valid this cycle.
- instr_mem_read_data  in  PROGRAM_MEM_DATA_BITS  fetched instruction.
- instruction  out  PROGRAM_MEM_DATA_BITS  latched current instruction.
- current_pc  out  PROGRAM_MEM_ADDR_BITS  program counter.
- latched_block_id  out  8  block_id captured at block start.
- thread_enable  out  THREADS_PER_BLOCK  bit i = 1 iff i < latched thread count.
- lsu_busy  in  THREADS_PER_BLOCK  per-thread outstanding memory op.
- core_state  out  3  state encoding, exposed to the pipeline.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- Reset values (all outputs and internal registers, reset dominates every other input):
  - core_state=IDLE; done=0; instr_mem_read_valid=0.
  - current_pc=0; instruction=0; latched_block_id=0; thread_enable=0.
- Reset mid-operation: everything returns to reset values on the next edge, including an in-flight fetch.
- IDLE, start=1 and done=0:
  - Latch block_id into latched_block_id.
  - Latch tc = min(thread_count, THREADS_PER_BLOCK) and set thread_enable from tc.
  - current_pc <= 0.
  - If thread_count==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - instr_mem_read_valid=1 while in FETCH; address = current_pc.
  - When instr_mem_read_ready=1: instruction <= instr_mem_read_data; valid <= 0; go to DECODE.
  - Otherwise stay in FETCH with valid held high; no timeout.
  - Ready while valid=0 is ignored.
- DECODE: 1 cycle, then REQUEST.
- REQUEST: 1 cycle (LSUs launch here), then WAIT.
- WAIT: stay while (lsu_busy & thread_enable) != 0; otherwise EXECUTE. Busy bits of disabled threads are ignored.
- EXECUTE: 1 cycle, then UPDATE.
- UPDATE, by opcode:
  - 4'hF (RET): go to DONE; PC unchanged.
  - 4'h9 (JMP): current_pc <= instruction[PROGRAM_MEM_ADDR_BITS-1:0]; go to FETCH.
  - Other: current_pc <= current_pc+1, wrapping modulo 2^PROGRAM_MEM_ADDR_BITS (0xFF -> 0x00 at default); go to FETCH.
- DONE:
  - done=1 (registered, asserted on entry).
  - Hold while start=1; when start=0: done <= 0 and go to IDLE.
  - A start that rises again in DONE after dropping is not seen until IDLE; the dispatcher always drops start first.
- start while not in IDLE is ignored. block_id and thread_count changes after the start latch have no effect.
- Minimum instruction latency, with ready in the first FETCH cycle and no busy: 6 cycles FETCH-to-FETCH.
- RET: UPDATE-to-done is 1 cycle.

Test Plan:
- Reset then start=1, block_id=3, thread_count=4; memory ready same cycle; program [0x1000, 0xF000]:
  - latched_block_id=3, thread_enable=4'b1111.
  - PCs fetched 0, 1.
  - done rises 12 cycles after FETCH entry.
  - done holds until start=0, then IDLE with done=0 next cycle.
- thread_count=2, lsu_busy=4'b1100 held throughout:
  - thread_enable=4'b0011; WAIT passes in 1 cycle.
  - Then lsu_busy=4'b0001 for 5 cycles: WAIT lasts exactly 5 extra cycles.
- thread_count=0: IDLE->DONE in one cycle; instr_mem_read_valid never asserts.
- thread_count=9 with THREADS_PER_BLOCK=4: thread_enable=4'b1111.
- Fetch backpressure, ready delayed 3 cycles:
  - valid and address stable for 4 cycles; instruction latched only on the ready cycle.
- JMP and PC wrap:
  - 0x9005 at PC 0 -> next fetch address 5.
  - Non-branch at PC 0xFF -> next fetch address 0x00.
- Reset asserted in WAIT: next cycle core_state=0, valid=0, pc=0, done=0; a subsequent start runs normally.
